// File: rtl/elevator_pkg.sv
// elevator_pkg: floor width, scheduler state and direction encodings shared by the call scheduler.
// Latency: none, types and constants only; backpressure: not applicable.
package elevator_pkg;

  localparam int FLOOR_W        = 3;
  localparam int NUM_FLOORS_DEF = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_SERVE  = 2'd2,
    ST_DWELL  = 2'd3
  } state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Floor codes are 1-based; 0 and anything above the top floor mean "car position unknown".
  function automatic logic floor_valid(input logic [FLOOR_W-1:0] f, input int n);
    return (f != '0) && (int'(f) <= n);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer, plus a stable-level filter when CALL_SCHED_DEBOUNCE_EN is defined.
// Latency: 2 clk (DEB_CYCLES more with the filter); backpressure: none, level in, level out.
module btn_debounce
  import elevator_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_clean
);

  logic sync_q1;
  logic sync_q2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

`ifdef CALL_SCHED_DEBOUNCE_EN
  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [CNT_W-1:0] cnt;
  logic             stable;

  // The accepted level only moves after DEB_CYCLES consecutive samples disagreeing with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync_q2 == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
      stable <= sync_q2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign btn_clean = stable;
`else
  logic unused_deb_cfg;
  assign unused_deb_cfg = (DEB_CYCLES > 0);

  assign btn_clean = sync_q2;
`endif

endmodule

// File: rtl/call_scheduler.sv
// call_scheduler: latches hall calls and runs a sweep-order IDLE/SELECT/SERVE/DWELL scheduler; option CALL_SCHED_DEBOUNCE_EN.
// Latency: press to pending 3 clk (+DEB_CYCLES filtered), pending to go 2 clk; backpressure: none, calls are held levels.
module call_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS   = NUM_FLOORS_DEF,
  parameter int DEB_CYCLES   = 1_000_000,
  parameter int DWELL_CYCLES = 250_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] btn,
  input  logic [FLOOR_W-1:0]    cur_floor,
  output logic [FLOOR_W-1:0]    target,
  output logic                  go,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  doors_open
);

  localparam int DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

  logic [NUM_FLOORS-1:0] btn_clean;
  logic [NUM_FLOORS-1:0] btn_prev;
  logic [NUM_FLOORS-1:0] btn_rise;
  logic [NUM_FLOORS-1:0] set_vec;
  logic [NUM_FLOORS-1:0] clr_vec;
  logic [NUM_FLOORS-1:0] cur_mask;
  logic                  cur_ok;

  state_t            state, state_n;
  dir_t              dir, dir_n;
  logic [FLOOR_W-1:0] target_n;
  logic              go_n;
  logic              doors_n;
  logic [DW_W-1:0]   dwell_cnt, dwell_n;

  logic               up_hit, dn_hit;
  logic [FLOOR_W-1:0] up_floor, dn_floor;

  for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_btn
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk      (clk),
      .rst      (rst),
      .btn_raw  (btn[i]),
      .btn_clean(btn_clean[i])
    );
  end

  assign cur_ok   = floor_valid(cur_floor, NUM_FLOORS);
  assign cur_mask = cur_ok ? (NUM_FLOORS'(1) << (cur_floor - 1'b1)) : '0;
  assign btn_rise = btn_clean & ~btn_prev;

  // A call for the floor whose doors are already open is satisfied, not queued.
  assign set_vec = btn_rise & ~((state == ST_DWELL) ? cur_mask : '0);
  assign clr_vec = (state == ST_SERVE && cur_ok && cur_floor == target) ? cur_mask : '0;

  always_comb begin
    up_hit   = 1'b0;
    dn_hit   = 1'b0;
    up_floor = '0;
    dn_floor = '0;
    for (int f = NUM_FLOORS; f >= 1; f--) begin
      if (pending[f-1] && f > int'(cur_floor)) begin
        up_hit   = 1'b1;
        up_floor = FLOOR_W'(f);
      end
    end
    for (int f = 1; f <= NUM_FLOORS; f++) begin
      if (pending[f-1] && f < int'(cur_floor)) begin
        dn_hit   = 1'b1;
        dn_floor = FLOOR_W'(f);
      end
    end
  end

  always_comb begin
    state_n  = state;
    dir_n    = dir;
    target_n = target;
    dwell_n  = dwell_cnt;
    doors_n  = 1'b0;
    go_n     = 1'b0;
    if (cur_ok) begin
      unique case (state)
        ST_IDLE: begin
          if (|pending) state_n = ST_SELECT;
        end
        ST_SELECT: begin
          state_n = ST_SERVE;
          if (dir == DIR_UP && up_hit) begin
            target_n = up_floor;
          end else if (dir == DIR_DOWN && dn_hit) begin
            target_n = dn_floor;
          end else if (dir == DIR_UP && dn_hit) begin
            dir_n    = DIR_DOWN;
            target_n = dn_floor;
          end else if (dir == DIR_DOWN && up_hit) begin
            dir_n    = DIR_UP;
            target_n = up_floor;
          end else if (|(pending & cur_mask)) begin
            target_n = cur_floor;
          end else begin
            state_n = ST_IDLE;
          end
        end
        ST_SERVE: begin
          if (cur_floor == target) begin
            state_n = ST_DWELL;
            dwell_n = '0;
            doors_n = 1'b1;
          end else if (dir == DIR_UP && up_hit && up_floor < target) begin
            target_n = up_floor;
          end else if (dir == DIR_DOWN && dn_hit && dn_floor > target) begin
            target_n = dn_floor;
          end
        end
        ST_DWELL: begin
          if (dwell_cnt == DW_W'(DWELL_CYCLES - 1)) begin
            state_n = (|pending) ? ST_SELECT : ST_IDLE;
          end else begin
            dwell_n = dwell_cnt + 1'b1;
            doors_n = 1'b1;
          end
        end
      endcase
    end else begin
      // Unknown car position: freeze everything until the elevator reports a real floor.
      doors_n = doors_open;
    end
    go_n = (state_n == ST_SERVE) && cur_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      dir        <= DIR_UP;
      target     <= FLOOR_W'(1);
      go         <= 1'b0;
      pending    <= '0;
      doors_open <= 1'b0;
      dwell_cnt  <= '0;
      btn_prev   <= '0;
    end else begin
      state      <= state_n;
      dir        <= dir_n;
      target     <= target_n;
      go         <= go_n;
      pending    <= (pending | set_vec) & ~clr_vec;
      doors_open <= doors_n;
      dwell_cnt  <= dwell_n;
      btn_prev   <= btn_clean;
    end
  end

endmodule

// File: tb/tb_call_scheduler.sv
// tb_call_scheduler: directed scenarios plus randomized call batches, with served floors checked by a scoreboard.
// A simple car model moves one floor every MOVE cycles while go is high.
module tb_call_scheduler;

  localparam int NF    = 7;
  localparam int DEB   = 4;
  localparam int DWELL = 8;
  localparam int MOVE  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NF-1:0] btn;
  logic [2:0]    cur_floor;
  logic [2:0]    target;
  logic          go;
  logic [NF-1:0] pending;
  logic          doors_open;

  int   checks = 0;
  int   errors = 0;
  int   exp_q[$];
  int   car_pos;
  logic bad;
  int   model_dir;

  always #5 clk = ~clk;

  call_scheduler #(.NUM_FLOORS(NF), .DEB_CYCLES(DEB), .DWELL_CYCLES(DWELL)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .cur_floor (cur_floor),
    .target    (target),
    .go        (go),
    .pending   (pending),
    .doors_open(doors_open)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timed_out(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  task automatic press(input int mask, input int n);
    btn = NF'(mask);
    repeat (n) @(negedge clk);
    btn = '0;
  endtask

  task automatic wait_go(input string name);
    int n = 0;
    while (go !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 200) begin timed_out(name); return; end
    end
  endtask

  task automatic wait_doors(input string name);
    int n = 0;
    while (doors_open !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 300) begin timed_out(name); return; end
    end
  endtask

  task automatic wait_target(input int t, input string name);
    int n = 0;
    while (int'(target) != t) begin
      @(negedge clk);
      n++;
      if (n > 20) begin timed_out(name); return; end
    end
  endtask

  task automatic wait_pending(input string name);
    int n = 0;
    while (pending == '0) begin
      @(negedge clk);
      n++;
      if (n > 20) begin timed_out(name); return; end
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(exp_q.size() == 0 && doors_open === 1'b0 && go === 1'b0 && pending == '0)) begin
      @(negedge clk);
      n++;
      if (n > 1500) begin timed_out(name); exp_q.delete(); return; end
    end
    @(negedge clk);
  endtask

  // Nearest call strictly beyond pos in direction d (0 up, 1 down); 0 if none.
  function automatic int nearest(input int pend, input int pos, input int d);
    int best = 0;
    for (int f = 1; f <= NF; f++) begin
      if (pend[f-1]) begin
        if (d == 0 && f > pos && (best == 0 || f < best)) best = f;
        if (d == 1 && f < pos && f > best) best = f;
      end
    end
    return best;
  endfunction

  initial begin : plant
    int mc;
    mc        = 0;
    car_pos   = 1;
    cur_floor = 3'd1;
    forever begin
      @(posedge clk);
      #1;
      if (go === 1'b1 && car_pos != int'(target)) begin
        mc++;
        if (mc == MOVE) begin
          mc      = 0;
          car_pos = (car_pos < int'(target)) ? car_pos + 1 : car_pos - 1;
        end
      end else begin
        mc = 0;
      end
      cur_floor = bad ? 3'd0 : 3'(car_pos);
    end
  end

  initial begin : monitor
    logic prev;
    int   dcnt;
    int   e;
    prev = 1'b0;
    dcnt = 0;
    forever begin
      @(negedge clk);
      if (doors_open === 1'b1 && !prev) begin
        dcnt = 0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_serve: doors opened at floor %0d with no call outstanding", target);
        end else begin
          e = exp_q.pop_front();
          check("serve_floor", int'(target), e);
          check("serve_car_pos", car_pos, e);
          check("serve_cleared", int'(pending[target-3'd1]), 0);
        end
      end
      if (doors_open === 1'b1) dcnt++;
      if (doors_open === 1'b0 && prev) check("dwell_len", dcnt, DWELL);
      prev = (doors_open === 1'b1);
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int found;
    int mask;
    int pend;
    int pos;
    int d;
    int nxt;

    rst       = 1'b1;
    btn       = '0;
    bad       = 1'b0;
    model_dir = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_target", int'(target), 1);
    check("rst_go", int'(go), 0);
    check("rst_pending", int'(pending), 0);
    check("rst_doors", int'(doors_open), 0);

    // Single call from floor 1 to floor 5.
    exp_q.push_back(5);
    btn = 7'h10;
    wait_pending("b_latch");
    check("b_pending", int'(pending), 'h10);
    found = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (go === 1'b1 && target == 3'd5) found = 1;
    end
    check("b_go_within_2", found, 1);
    repeat (5) @(negedge clk);
    btn = '0;
    wait_idle("b_idle");
    check("b_pending_clear", int'(pending), 0);
    repeat (4) @(negedge clk);
    check("b_idle_go", int'(go), 0);

    // Car to floor 2, then serve 6 with a pick-up at 4 on the way.
    exp_q.push_back(2);
    press('h02, 6);
    wait_idle("c_to2");
    exp_q.push_back(4);
    exp_q.push_back(6);
    press('h20, 6);
    wait_go("c_go6");
    press('h08, 6);
    wait_target(4, "c_retarget");
    check("c_retarget_4", int'(target), 4);
    wait_doors("c_doors4");
    while (doors_open === 1'b1) @(negedge clk);
    wait_go("c_resume");
    check("c_resume_target", int'(target), 6);
    wait_idle("c_idle");

    // Bring the car to 4 heading up, then calls 2 and 6: sweep up first.
    exp_q.push_back(1);
    press('h01, 6);
    wait_idle("d_to1");
    exp_q.push_back(4);
    press('h08, 6);
    wait_idle("d_to4");
    exp_q.push_back(6);
    exp_q.push_back(2);
    press('h22, 6);
    wait_go("d_go");
    check("d_first_target", int'(target), 6);
    wait_idle("d_idle");

    // During dwell at 3 the floor-3 call is dropped, the floor-7 call latches.
    exp_q.push_back(3);
    press('h04, 6);
    wait_doors("e_doors3");
    exp_q.push_back(7);
    press('h44, 6);
    repeat (3) @(negedge clk);
    check("e_discard_cur", int'(pending), 'h40);
    wait_idle("e_idle");

    // A 3-cycle pulse.
`ifdef CALL_SCHED_DEBOUNCE_EN
    press('h01, 3);
    repeat (6) @(negedge clk);
    check("f_short_pulse_ignored", int'(pending), 0);
`else
    exp_q.push_back(1);
    press('h01, 3);
    check("f_short_pulse_latched", int'(pending), 'h01);
    wait_idle("f_idle");
`endif

    // Invalid car position freezes the scheduler.
    exp_q.push_back(3);
    press('h04, 6);
    wait_go("g_go");
    bad = 1'b1;
    repeat (2) @(negedge clk);
    check("g_invalid_go", int'(go), 0);
    repeat (5) @(negedge clk);
    check("g_hold_go", int'(go), 0);
    check("g_hold_target", int'(target), 3);
    check("g_hold_doors", int'(doors_open), 0);
    bad = 1'b0;
    wait_go("g_resume");
    check("g_resume_target", int'(target), 3);
    wait_idle("g_idle");

    // Reset in the middle of a serve drops every call.
    press('h41, 6);
    wait_go("h_go");
    check("h_pending", int'(pending), 'h41);
    rst = 1'b1;
    @(negedge clk);
    check("h_rst_go", int'(go), 0);
    check("h_rst_target", int'(target), 1);
    check("h_rst_pending", int'(pending), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("h_after_rst_go", int'(go), 0);
    model_dir = 0;

    // Randomized call batches, served order predicted by the sweep rule.
    for (int b = 0; b < 8; b++) begin
      mask = $urandom_range(1, 127);
      pend = mask;
      pos  = car_pos;
      d    = model_dir;
      while (pend != 0) begin
        nxt = nearest(pend, pos, d);
        if (nxt == 0) begin
          nxt = nearest(pend, pos, 1 - d);
          if (nxt != 0) d = 1 - d;
          else nxt = pos;
        end
        exp_q.push_back(nxt);
        pend = pend & ~(1 << (nxt - 1));
        pos  = nxt;
      end
      model_dir = d;
      press(mask, 6);
      wait_idle("rand_idle");
    end

    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
